axi_decerr_slv: RTL and testbench
=================================

Name: axi_decerr_slv

Overview:
- Default AXI4 responder on the SoC crossbar; it is the target for every address that misses all rules in the SoC address map (DRAM, GPIO, Ethernet, SPI, Timer, UART, PLIC, CLINT, ROM, Debug).
- It completes each stray transaction cleanly with DECERR, so no master hangs.
- The read and write paths are independent, with one outstanding transaction per direction.
- Full burst length is honoured on reads; write data is absorbed until wlast.

Parameters:
- ID_WIDTH, 5, AXI ID width seen at the slave port (master ID width 4 plus 1 bit for 2 crossbar masters).
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 64, AXI data width.
- DATA_PATTERN, 64'hDEAD_BEEF_DEAD_BEEF, rdata value returned on every read beat.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- aw_id_i  in  ID_WIDTH  write address ID
- aw_addr_i  in  ADDR_WIDTH  write address
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- w_last_i  in  1  last write beat
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- b_id_o  out  ID_WIDTH  write response ID
- b_resp_o  out  2  write response, always 2'b11
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- ar_id_i  in  ID_WIDTH  read address ID
- ar_addr_i  in  ADDR_WIDTH  read address
- ar_len_i  in  8  read burst length minus 1
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- r_id_o  out  ID_WIDTH  read ID
- r_data_o  out  DATA_WIDTH  read data
- r_resp_o  out  2  read response, always 2'b11
- r_last_o  out  1  last read beat
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- err_count_o  out  32  number of accepted stray transactions (ERR_LOG_EN)
- err_addr_o  out  ADDR_WIDTH  address of the most recent stray transaction (ERR_LOG_EN)
- err_is_write_o  out  1  most recent stray transaction was a write (ERR_LOG_EN)

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous and active-high.
- While rst_i=1, both FSMs go to IDLE. All valid and ready outputs are 0. The ID registers, beat counter and err_* outputs are cleared to 0.
- Write FSM:
  - W_IDLE: aw_ready_o=1. On an AW handshake, latch aw_id_i and go to W_DATA.
  - W_DATA: w_ready_o=1. Data is discarded. On a handshake with w_last_i=1, go to W_RESP. aw_len is not tracked; the burst ends on wlast only.
  - W_RESP: b_valid_o=1, b_id_o=latched ID, b_resp_o=2'b11. On b_ready_i, go to W_IDLE.
- Read FSM:
  - R_IDLE: ar_ready_o=1. On an AR handshake, latch ar_id_i, load beat counter=ar_len_i and go to R_DATA.
  - R_DATA: r_valid_o=1, r_data_o=DATA_PATTERN, r_resp_o=2'b11, r_id_o=latched ID, r_last_o=(counter==0).
  - In R_DATA, each handshake with counter≠0 decrements the counter. A handshake with counter==0 returns to R_IDLE.
- Latency:
  - AW handshake in cycle N → w_ready_o=1 in N+1.
  - Last W handshake in M → b_valid_o=1 in M+1.
  - AR handshake in N → first r_valid_o in N+1.
  - Beats are back-to-back while r_ready_i=1.
  - Back-to-back transactions in the same direction cost one idle cycle between them.
- Handshake rules:
  - All outputs are registered state decodes and never depend combinationally on any input.
  - While valid=1 and ready=0, all payload outputs are held stable.
  - W beats presented before AW are not accepted (w_ready_o=0 outside W_DATA).
- The AW and AR paths are fully concurrent. Simultaneous AW and AR handshakes are both accepted in the same cycle.
- ar_len_i=255 gives 256 beats. The 8-bit counter never wraps below 0.
- Reset mid-burst: the transaction is dropped. No further beats or B response are produced after reset.

Optional Feature:
- Macro: AXI_DECERR_SLV_ERR_LOG_EN.
- With the macro defined:
  - err_count_o increments once per accepted AW or AR handshake, and by 2 when both happen in the same cycle.
  - err_count_o saturates at 32'hFFFF_FFFF.
  - err_addr_o and err_is_write_o capture the address and direction of the handshake. When AW and AR handshake in the same cycle, the write wins.
  - All three outputs update the cycle after the handshake.
- Without the macro: the err_* ports exist but are tied to 0, and no logging flops are built.

Test Plan:
- Single-beat write: AW id=5'h13 addr=0x5000_0000, then one W beat with wlast → b_valid_o one cycle after the W handshake, b_id_o=5'h13, b_resp_o=2'b11; aw_ready_o=0 until the B handshake.
- Read burst: AR id=5'h07 len=3 with r_ready_i=1 → 4 consecutive beats, each with r_data_o=DATA_PATTERN and r_resp_o=2'b11; r_last_o=1 only on beat 4; ar_ready_o=1 the cycle after beat 4.
- Backpressure: b_ready_i=0 for 5 cycles, then r_ready_i toggled every cycle on a len=7 read → b_valid_o and b_id_o hold stable; exactly 8 R beats; payload is stable while r_ready_i=0.
- Concurrency: AW and AR asserted in the same cycle, W withheld → the read completes fully while the write sits in W_DATA; sending W then yields the B response.
- Reset mid-operation: rst_i pulsed after 2 of 8 read beats → r_valid_o=0 next cycle; after release ar_ready_o=1 and no stale beats appear.
- ERR_LOG_EN: write to 0x6000_0000, then a read from 0x7000_0000, then AW+AR simultaneous with AW addr 0x9... / AR 0x1 → err_count_o=4, err_addr_o=AW addr, err_is_write_o=1; a forced count of 32'hFFFF_FFFE plus 2 further errors → saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/axi_decerr_slv_if.sv
// AXI4 slave-port bundle for the DECERR default responder, holding only the fields it uses.
interface axi_decerr_slv_if #(
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   aw_id_i;
  logic [ADDR_WIDTH-1:0] aw_addr_i;
  logic                  aw_valid_i;
  logic                  aw_ready_o;
  logic                  w_last_i;
  logic                  w_valid_i;
  logic                  w_ready_o;
  logic [ID_WIDTH-1:0]   b_id_o;
  logic [1:0]            b_resp_o;
  logic                  b_valid_o;
  logic                  b_ready_i;
  logic [ID_WIDTH-1:0]   ar_id_i;
  logic [ADDR_WIDTH-1:0] ar_addr_i;
  logic [7:0]            ar_len_i;
  logic                  ar_valid_i;
  logic                  ar_ready_o;
  logic [ID_WIDTH-1:0]   r_id_o;
  logic [DATA_WIDTH-1:0] r_data_o;
  logic [1:0]            r_resp_o;
  logic                  r_last_o;
  logic                  r_valid_o;
  logic                  r_ready_i;

  modport slave (
    input  aw_id_i, aw_addr_i, aw_valid_i, w_last_i, w_valid_i, b_ready_i,
    input  ar_id_i, ar_addr_i, ar_len_i, ar_valid_i, r_ready_i,
    output aw_ready_o, w_ready_o, b_id_o, b_resp_o, b_valid_o,
    output ar_ready_o, r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o
  );

  modport master (
    output aw_id_i, aw_addr_i, aw_valid_i, w_last_i, w_valid_i, b_ready_i,
    output ar_id_i, ar_addr_i, ar_len_i, ar_valid_i, r_ready_i,
    input  aw_ready_o, w_ready_o, b_id_o, b_resp_o, b_valid_o,
    input  ar_ready_o, r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o
  );
endinterface

// File: rtl/axi_decerr_slv.sv
// Default AXI4 responder: completes every stray transaction with DECERR, one outstanding per direction.
// Define AXI_DECERR_SLV_ERR_LOG_EN to build the error count/address/direction log.
module axi_decerr_slv #(
  parameter int                    ID_WIDTH     = 5,
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 64,
  parameter logic [DATA_WIDTH-1:0] DATA_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi_decerr_slv_if.slave       bus,
  output logic [31:0]           err_count_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  err_is_write_o
);
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  wr_state_t           wr_state;
  rd_state_t           rd_state;
  logic                aw_ready_q;
  logic                w_ready_q;
  logic                b_valid_q;
  logic [ID_WIDTH-1:0] b_id_q;
  logic                ar_ready_q;
  logic                r_valid_q;
  logic                r_last_q;
  logic [ID_WIDTH-1:0] r_id_q;
  logic [7:0]          beat_cnt;
  logic                aw_hs;
  logic                ar_hs;

  assign aw_hs = bus.aw_valid_i && aw_ready_q;
  assign ar_hs = bus.ar_valid_i && ar_ready_q;

  // Ready/valid flops are loaded with the decode of the next state, so every output is a flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state   <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            b_id_q     <= bus.aw_id_i;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            wr_state   <= W_DATA;
          end else begin
            aw_ready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (bus.w_valid_i && w_ready_q && bus.w_last_i) begin
            w_ready_q <= 1'b0;
            b_valid_q <= 1'b1;
            wr_state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (bus.b_ready_i && b_valid_q) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            wr_state   <= W_IDLE;
          end
        end
        default: begin
          aw_ready_q <= 1'b0;
          w_ready_q  <= 1'b0;
          b_valid_q  <= 1'b0;
          wr_state   <= W_IDLE;
        end
      endcase
    end
  end

  // The beat counter holds beats remaining after the current one; it stops at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state   <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      beat_cnt   <= '0;
    end else if (rd_state == R_IDLE) begin
      if (ar_hs) begin
        r_id_q     <= bus.ar_id_i;
        beat_cnt   <= bus.ar_len_i;
        ar_ready_q <= 1'b0;
        r_valid_q  <= 1'b1;
        r_last_q   <= (bus.ar_len_i == 8'd0);
        rd_state   <= R_DATA;
      end else begin
        ar_ready_q <= 1'b1;
      end
    end else if (bus.r_ready_i && r_valid_q) begin
      if (beat_cnt == 8'd0) begin
        r_valid_q  <= 1'b0;
        r_last_q   <= 1'b0;
        ar_ready_q <= 1'b1;
        rd_state   <= R_IDLE;
      end else begin
        beat_cnt <= beat_cnt - 8'd1;
        r_last_q <= (beat_cnt == 8'd1);
      end
    end
  end

  assign bus.aw_ready_o = aw_ready_q;
  assign bus.w_ready_o  = w_ready_q;
  assign bus.b_valid_o  = b_valid_q;
  assign bus.b_id_o     = b_id_q;
  assign bus.b_resp_o   = DECERR;
  assign bus.ar_ready_o = ar_ready_q;
  assign bus.r_valid_o  = r_valid_q;
  assign bus.r_last_o   = r_last_q;
  assign bus.r_id_o     = r_id_q;
  assign bus.r_data_o   = DATA_PATTERN;
  assign bus.r_resp_o   = DECERR;

`ifdef AXI_DECERR_SLV_ERR_LOG_EN
  logic [31:0]           err_count_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic                  err_is_write_q;
  logic [32:0]           err_sum;

  assign err_sum = {1'b0, err_count_q} + 33'(aw_hs) + 33'(ar_hs);

  // A carry out of the 33-bit sum means the count would pass all-ones, so it pins there.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_q    <= '0;
      err_addr_q     <= '0;
      err_is_write_q <= 1'b0;
    end else begin
      err_count_q <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
      if (aw_hs) begin
        err_addr_q     <= bus.aw_addr_i;
        err_is_write_q <= 1'b1;
      end else if (ar_hs) begin
        err_addr_q     <= bus.ar_addr_i;
        err_is_write_q <= 1'b0;
      end
    end
  end

  assign err_count_o    = err_count_q;
  assign err_addr_o     = err_addr_q;
  assign err_is_write_o = err_is_write_q;
`else
  logic unused_addr;
  assign unused_addr    = ^{bus.aw_addr_i, bus.ar_addr_i};
  assign err_count_o    = '0;
  assign err_addr_o     = '0;
  assign err_is_write_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi_decerr_slv.sv
// Bench for axi_decerr_slv: directed protocol steps, then random transactions checked against a
// transaction-level model (beat counts, IDs, DECERR, error log). Honours AXI_DECERR_SLV_ERR_LOG_EN.
module tb_axi_decerr_slv;
  localparam int          ID_W    = 5;
  localparam int          ADDR_W  = 64;
  localparam int          DATA_W  = 64;
  localparam logic [63:0] PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int          BOUND   = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       err_count;
  logic [ADDR_W-1:0] err_addr;
  logic              err_is_write;

  int total = 0;
  int bad   = 0;

  logic aw_hs_last = 1'b0;
  logic w_hs_last  = 1'b0;
  logic b_hs_last  = 1'b0;
  logic ar_hs_last = 1'b0;
  logic r_hs_last  = 1'b0;

  longint      exp_cnt  = 0;
  logic [63:0] exp_addr = '0;
  logic        exp_wr   = 1'b0;

  axi_decerr_slv_if #(.ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W)) bus ();

  axi_decerr_slv #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .DATA_PATTERN(PATTERN)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus.slave),
    .err_count_o(err_count),
    .err_addr_o(err_addr),
    .err_is_write_o(err_is_write)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic aw_v, input logic w_v, input logic w_l,
                               input logic b_r, input logic ar_v, input logic r_r);
    bus.aw_valid_i = aw_v;
    bus.w_valid_i  = w_v;
    bus.w_last_i   = w_l;
    bus.b_ready_i  = b_r;
    bus.ar_valid_i = ar_v;
    bus.r_ready_i  = r_r;
  endtask

  // Advance one clock; handshakes are judged from values stable before the edge, and the
  // error-log model counts every accepted address, saturating, with writes winning ties.
  task automatic tick();
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, in_rst;
    logic [63:0] awa, ara;
    in_rst = rst;
    aw_hs  = bus.aw_valid_i && bus.aw_ready_o;
    w_hs   = bus.w_valid_i && bus.w_ready_o;
    b_hs   = bus.b_valid_o && bus.b_ready_i;
    ar_hs  = bus.ar_valid_i && bus.ar_ready_o;
    r_hs   = bus.r_valid_o && bus.r_ready_i;
    awa    = bus.aw_addr_i;
    ara    = bus.ar_addr_i;
    @(posedge clk);
    #1;
    aw_hs_last = aw_hs && !in_rst;
    w_hs_last  = w_hs && !in_rst;
    b_hs_last  = b_hs && !in_rst;
    ar_hs_last = ar_hs && !in_rst;
    r_hs_last  = r_hs && !in_rst;
    if (in_rst) begin
      exp_cnt  = 0;
      exp_addr = '0;
      exp_wr   = 1'b0;
    end else begin
      exp_cnt = exp_cnt + longint'(aw_hs_last) + longint'(ar_hs_last);
      if (exp_cnt > 64'h0000_0000_FFFF_FFFF) exp_cnt = 64'h0000_0000_FFFF_FFFF;
      if (aw_hs_last) begin
        exp_addr = awa;
        exp_wr   = 1'b1;
      end else if (ar_hs_last) begin
        exp_addr = ara;
        exp_wr   = 1'b0;
      end
    end
  endtask

  task automatic checkLog(input string tag);
`ifdef AXI_DECERR_SLV_ERR_LOG_EN
    checkOutput({tag, "_err_count"}, 64'(err_count), 64'(exp_cnt));
    checkOutput({tag, "_err_addr"}, err_addr, exp_addr);
    checkOutput({tag, "_err_is_write"}, 64'(err_is_write), 64'(exp_wr));
`else
    checkOutput({tag, "_err_count"}, 64'(err_count), 64'd0);
    checkOutput({tag, "_err_addr"}, err_addr, 64'd0);
    checkOutput({tag, "_err_is_write"}, 64'(err_is_write), 64'd0);
`endif
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_aw_ready"}, 64'(bus.aw_ready_o), 64'd1);
    checkOutput({tag, "_ar_ready"}, 64'(bus.ar_ready_o), 64'd1);
    checkOutput({tag, "_w_ready"}, 64'(bus.w_ready_o), 64'd0);
    checkOutput({tag, "_b_valid"}, 64'(bus.b_valid_o), 64'd0);
    checkOutput({tag, "_r_valid"}, 64'(bus.r_valid_o), 64'd0);
  endtask

  // Present AW and/or AR until each is accepted; payload is scrambled right after acceptance
  // so later checks prove the DUT latched it.
  task automatic addr_phase(input logic do_aw, input logic [ID_W-1:0] awid, input logic [63:0] awaddr,
                            input logic do_ar, input logic [ID_W-1:0] arid, input logic [63:0] araddr,
                            input logic [7:0] arlen);
    logic got_aw, got_ar;
    int n;
    got_aw = !do_aw;
    got_ar = !do_ar;
    n = 0;
    bus.aw_id_i = awid; bus.aw_addr_i = awaddr; bus.aw_valid_i = do_aw;
    bus.ar_id_i = arid; bus.ar_addr_i = araddr; bus.ar_len_i = arlen; bus.ar_valid_i = do_ar;
    while (!(got_aw && got_ar) && n < BOUND) begin
      tick();
      n++;
      if (aw_hs_last) begin
        got_aw = 1'b1;
        bus.aw_valid_i = 1'b0;
        bus.aw_id_i    = ID_W'($urandom);
        bus.aw_addr_i  = {$urandom, $urandom};
      end
      if (ar_hs_last) begin
        got_ar = 1'b1;
        bus.ar_valid_i = 1'b0;
        bus.ar_id_i    = ID_W'($urandom);
        bus.ar_addr_i  = {$urandom, $urandom};
        bus.ar_len_i   = 8'($urandom);
      end
    end
    bus.aw_valid_i = 1'b0;
    bus.ar_valid_i = 1'b0;
    if (do_aw) begin
      checkOutput("aw_accept", 64'(got_aw), 64'd1);
      checkOutput("w_ready_after_aw", 64'(bus.w_ready_o), 64'd1);
      checkOutput("aw_ready_busy", 64'(bus.aw_ready_o), 64'd0);
    end
    if (do_ar) begin
      checkOutput("ar_accept", 64'(got_ar), 64'd1);
      checkOutput("r_valid_after_ar", 64'(bus.r_valid_o), 64'd1);
      checkOutput("ar_ready_busy", 64'(bus.ar_ready_o), 64'd0);
    end
  endtask

  task automatic write_data(input logic [ID_W-1:0] id, input int beats, input int bdelay);
    int gap;
    for (int b = 0; b < beats; b++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        checkOutput("w_ready_hold", 64'(bus.w_ready_o), 64'd1);
        checkOutput("b_quiet_in_data", 64'(bus.b_valid_o), 64'd0);
      end
      bus.w_valid_i = 1'b1;
      bus.w_last_i  = (b == beats - 1);
      tick();
      checkOutput("w_accept", 64'(w_hs_last), 64'd1);
      bus.w_valid_i = 1'b0;
      bus.w_last_i  = 1'b0;
      if (b != beats - 1) checkOutput("b_early", 64'(bus.b_valid_o), 64'd0);
    end
    checkOutput("b_valid", 64'(bus.b_valid_o), 64'd1);
    checkOutput("b_id", 64'(bus.b_id_o), 64'(id));
    checkOutput("b_resp", 64'(bus.b_resp_o), 64'd3);
    checkOutput("w_ready_in_resp", 64'(bus.w_ready_o), 64'd0);
    checkOutput("aw_ready_in_resp", 64'(bus.aw_ready_o), 64'd0);
    bus.b_ready_i = 1'b0;
    for (int d = 0; d < bdelay; d++) begin
      tick();
      checkOutput("b_valid_hold", 64'(bus.b_valid_o), 64'd1);
      checkOutput("b_id_hold", 64'(bus.b_id_o), 64'(id));
      checkOutput("aw_ready_held_low", 64'(bus.aw_ready_o), 64'd0);
    end
    bus.b_ready_i = 1'b1;
    tick();
    checkOutput("b_accept", 64'(b_hs_last), 64'd1);
    bus.b_ready_i = 1'b0;
    checkOutput("b_done", 64'(bus.b_valid_o), 64'd0);
    checkOutput("aw_ready_back", 64'(bus.aw_ready_o), 64'd1);
  endtask

  // mode 0: always ready, 1: ready toggles every cycle, 2: random ready.
  task automatic read_data(input logic [ID_W-1:0] id, input logic [7:0] len, input int mode);
    int beats, n, limit;
    logic rr;
    beats = 0;
    n     = 0;
    limit = 4 * (int'(len) + 1) + 20;
    while (beats <= int'(len) && n < limit) begin
      checkOutput("r_valid", 64'(bus.r_valid_o), 64'd1);
      if (bus.r_valid_o !== 1'b1) break;
      checkOutput("r_data", bus.r_data_o, PATTERN);
      checkOutput("r_resp", 64'(bus.r_resp_o), 64'd3);
      checkOutput("r_id", 64'(bus.r_id_o), 64'(id));
      checkOutput("r_last", 64'(bus.r_last_o), 64'(beats == int'(len)));
      checkOutput("ar_ready_in_burst", 64'(bus.ar_ready_o), 64'd0);
      case (mode)
        0:       rr = 1'b1;
        1:       rr = n[0];
        default: rr = 1'($urandom_range(0, 1));
      endcase
      bus.r_ready_i = rr;
      tick();
      n++;
      if (r_hs_last) beats++;
    end
    bus.r_ready_i = 1'b0;
    checkOutput("r_beat_count", 64'(beats), 64'(int'(len) + 1));
    checkOutput("r_done", 64'(bus.r_valid_o), 64'd0);
    checkOutput("ar_ready_back", 64'(bus.ar_ready_o), 64'd1);
  endtask

  initial begin : main
    int          kind, beats, bdelay, mode;
    logic [7:0]  len;
    logic [4:0]  wid, rid;
    logic [63:0] wa, ra;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.aw_id_i = '0; bus.aw_addr_i = '0;
    bus.ar_id_i = '0; bus.ar_addr_i = '0; bus.ar_len_i = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_aw_ready", 64'(bus.aw_ready_o), 64'd0);
    checkOutput("rst_w_ready", 64'(bus.w_ready_o), 64'd0);
    checkOutput("rst_b_valid", 64'(bus.b_valid_o), 64'd0);
    checkOutput("rst_ar_ready", 64'(bus.ar_ready_o), 64'd0);
    checkOutput("rst_r_valid", 64'(bus.r_valid_o), 64'd0);
    checkOutput("rst_b_id", 64'(bus.b_id_o), 64'd0);
    checkOutput("rst_r_id", 64'(bus.r_id_o), 64'd0);
    checkLog("rst");
    rst = 1'b0;
    tick();
    checkIdle("post_rst");

    // W presented before AW is not accepted
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("w_before_aw_ready", 64'(bus.w_ready_o), 64'd0);
    checkOutput("w_before_aw_b", 64'(bus.b_valid_o), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-beat write
    addr_phase(1'b1, 5'h13, 64'h5000_0000, 1'b0, '0, '0, '0);
    checkLog("wr1");
    write_data(5'h13, 1, 0);

    // Read burst of 4
    addr_phase(1'b0, '0, '0, 1'b1, 5'h07, 64'h3000_0000, 8'd3);
    checkLog("rd4");
    read_data(5'h07, 8'd3, 0);

    // Backpressure on B, then toggled r_ready on an 8-beat read
    addr_phase(1'b1, 5'h0A, 64'h4000_1000, 1'b0, '0, '0, '0);
    write_data(5'h0A, 3, 5);
    addr_phase(1'b0, '0, '0, 1'b1, 5'h15, 64'h4000_2000, 8'd7);
    read_data(5'h15, 8'd7, 1);

    // Concurrent AW and AR; read completes while the write waits for data
    addr_phase(1'b1, 5'h11, 64'hA000_0000, 1'b1, 5'h02, 64'hB000_0000, 8'd5);
    checkOutput("aw_ar_same_cycle", 64'({aw_hs_last, ar_hs_last}), 64'd3);
    checkLog("concurrent");
    read_data(5'h02, 8'd5, 2);
    checkOutput("write_parked_w_ready", 64'(bus.w_ready_o), 64'd1);
    checkOutput("write_parked_b", 64'(bus.b_valid_o), 64'd0);
    write_data(5'h11, 2, 1);

    // Length boundaries
    addr_phase(1'b0, '0, '0, 1'b1, 5'h1E, 64'hC000_0000, 8'd255);
    read_data(5'h1E, 8'd255, 0);
    addr_phase(1'b0, '0, '0, 1'b1, 5'h01, 64'hC000_0040, 8'd0);
    read_data(5'h01, 8'd0, 2);

    // Reset mid-operation: write parked in data phase, read after 2 of 8 beats
    addr_phase(1'b1, 5'h1F, 64'hD000_0000, 1'b1, 5'h09, 64'hD000_1000, 8'd7);
    bus.r_ready_i = 1'b1;
    tick();
    checkOutput("pre_rst_beat1", 64'(r_hs_last), 64'd1);
    tick();
    checkOutput("pre_rst_beat2", 64'(r_hs_last), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_r_valid", 64'(bus.r_valid_o), 64'd0);
    checkOutput("mid_rst_w_ready", 64'(bus.w_ready_o), 64'd0);
    checkOutput("mid_rst_r_id", 64'(bus.r_id_o), 64'd0);
    checkLog("mid_rst");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkIdle("after_mid_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_stale_r", 64'(bus.r_valid_o), 64'd0);
      checkOutput("no_stale_b", 64'(bus.b_valid_o), 64'd0);
      checkOutput("no_stale_w_ready", 64'(bus.w_ready_o), 64'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Error log: write, read, then simultaneous write+read where the write wins
    addr_phase(1'b1, 5'h03, 64'h6000_0000, 1'b0, '0, '0, '0);
    write_data(5'h03, 1, 0);
    addr_phase(1'b0, '0, '0, 1'b1, 5'h04, 64'h7000_0000, 8'd0);
    read_data(5'h04, 8'd0, 0);
    addr_phase(1'b1, 5'h05, 64'h9000_0000_0000_0000, 1'b1, 5'h06, 64'h1, 8'd0);
    checkLog("log_both");
`ifdef AXI_DECERR_SLV_ERR_LOG_EN
    checkOutput("log_count_four", 64'(err_count), 64'd4);
    checkOutput("log_addr_write_wins", err_addr, 64'h9000_0000_0000_0000);
    checkOutput("log_dir_write_wins", 64'(err_is_write), 64'd1);
`endif
    read_data(5'h06, 8'd0, 0);
    write_data(5'h05, 1, 0);

`ifdef AXI_DECERR_SLV_ERR_LOG_EN
    force dut.err_count_q = 32'hFFFF_FFFE;
    tick();
    release dut.err_count_q;
    exp_cnt = 64'h0000_0000_FFFF_FFFE;
    addr_phase(1'b1, 5'h07, 64'h8000_0000, 1'b1, 5'h08, 64'h8000_0100, 8'd0);
    checkOutput("log_saturate", 64'(err_count), 64'hFFFF_FFFF);
    read_data(5'h08, 8'd0, 0);
    write_data(5'h07, 1, 0);
    addr_phase(1'b0, '0, '0, 1'b1, 5'h09, 64'h8000_0200, 8'd0);
    checkOutput("log_saturate_hold", 64'(err_count), 64'hFFFF_FFFF);
    read_data(5'h09, 8'd0, 0);
`endif

    // Random transactions against the model
    for (int t = 0; t < 30; t++) begin
      kind   = $urandom_range(0, 2);
      wid    = 5'($urandom);
      rid    = 5'($urandom);
      wa     = {$urandom, $urandom};
      ra     = {$urandom, $urandom};
      len    = 8'($urandom_range(0, 15));
      beats  = $urandom_range(1, 4);
      bdelay = $urandom_range(0, 3);
      mode   = $urandom_range(0, 2);
      addr_phase(kind != 1, wid, wa, kind != 0, rid, ra, len);
      checkLog("rand_addr");
      if (kind != 0) read_data(rid, len, mode);
      if (kind != 1) write_data(wid, beats, bdelay);
      checkIdle("rand_idle");
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
